down_counter_reload: RTL and testbench
======================================

# down_counter_reload

Loadable, parameterized down-counter with terminal-count detection and optional auto-reload. It is the counterpart to the team's 3-bit up counter. It counts a programmed value down to zero under an enable, and flags completion with a one-cycle terminal-count pulse and a sticky done flag. It is used as a cycle/event timer beside the up counter in the same clock domain.

## Interface
- WIDTH, 3, counter and load-value width in bits
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- load  in  1  capture load_val into counter and reload register
- load_val  in  WIDTH  value to count down from
- en  in  1  decrement enable, one step per cycle while high
- auto_reload  in  1  1: reload at terminal count; 0: stop at zero (one-shot)
- count  out  WIDTH  current counter value
- busy  out  1  high while in RUN
- tc  out  1  terminal-count pulse, one cycle wide
- done  out  1  sticky one-shot completion flag, cleared by load

## Operation
- FSM states:
  - IDLE: holding, not counting.
  - RUN: counting.
  - DONE: one-shot complete.
- busy is 1 only in RUN. done is 1 only in DONE.
- Reset (rst low, asynchronous) forces the following at once:
  - state IDLE
  - count 0, reload register 0
  - tc 0, busy 0, done 0
- Priority, highest first: rst, then load, then en.
- load, any state:
  - count and the reload register take load_val.
  - The next state is RUN if load_val != 0, otherwise IDLE.
  - tc is 0 that cycle. done clears.
  - en is ignored in the same cycle, so there is no decrement.
- RUN, en=1, count > 1: count decrements by 1.
- RUN, en=1, count == 1 (terminal):
  - tc=1 for exactly one cycle.
  - auto_reload=1: count takes the reload register value and the state stays RUN.
  - auto_reload=0: count becomes 0 and the state goes to DONE.
- RUN, en=0: all state holds and tc=0.
- IDLE and DONE: count holds and en is ignored. Only load leaves either state.
- auto_reload is sampled only on the terminal cycle. Changing it mid-count has no other effect.
- Counting never goes below 0, so there is no modular wrap. In auto-reload mode the count never reads 0 and the period is the reload value in enabled cycles.
- load_val = 2^WIDTH-1 (7 for the default) is legal and counts the full range.

## Timing
- All outputs are registered. count, tc, busy and done change only on clk rising edges, except for the asynchronous reset.
- Load latency: count = load_val and busy=1 are visible one cycle after the edge that samples load.
- With en held high after load of N at edge 0:
  - count shows N, N-1, ..., 1 after edges 0..N-1.
  - tc is high for the single cycle following edge N, coincident with the update of count to 0 (one-shot) or to N (reload).
  - One-shot: busy falls and done rises at edge N.
  - Auto-reload: tc repeats every N enabled cycles.
- load on the terminal cycle: load wins, tc stays 0, count = new load_val.
- Reset mid-RUN: outputs take their reset values immediately. Any tc pulse in progress is cut short.

## Structure
- Shared package down_counter_pkg holds:
  - 2-bit state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default width constant COUNT_W = 3.
- Single module. No sub-module is warranted: one state register, one count register, one reload register and the tc flop.

## Test plan
- One-shot: load 5, en=1 continuously -> count 5,4,3,2,1,0; tc=1 only on the cycle count becomes 0; then busy=0, done=1, count holds 0.
- Auto-reload: load 3, auto_reload=1, en=1 for 9 cycles -> count 3,2,1,3,2,1,3,2,1; tc pulses on each 1->3 transition; busy stays 1; done stays 0.
- En gating: load 4, en pattern 1,0,1,1,0,1 -> count 4,3,3,2,1,1,0; tc only on the final step.
- Load priority: load 6 on the cycle count==1 with en=1 -> count 6, tc=0, busy=1, no DONE.
- Load zero and full scale:
  - load 0 -> count 0, IDLE, busy=0, done=0, tc never asserts.
  - load 7 with en=1 -> tc 7 cycles later.
- Async reset mid-run: load 5, en=1, drive rst low between edges after 2 decrements -> count=0, busy=0, done=0, tc=0 before the next clk edge. After rst is released, en=1 alone does nothing.

Source files
------------

// File: rtl/down_counter_pkg.sv
// Shared definitions for the loadable down-counter.
//   state_e : FSM encoding (IDLE holding, RUN counting, DONE one-shot complete)
//   COUNT_W : default counter / load-value width
package down_counter_pkg;

  localparam int unsigned COUNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/down_counter_reload.sv
// Loadable down-counter with terminal-count pulse and optional auto-reload.
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   load        : capture load_val into count and reload register (beats en)
//   load_val    : value to count down from
//   en          : decrement enable, one step per cycle while in RUN
//   auto_reload : sampled at terminal count; 1 reloads, 0 stops in DONE
//   count       : current counter value
//   busy        : high in RUN
//   tc          : one-cycle terminal-count pulse
//   done        : sticky completion flag, cleared by load
module down_counter_reload
  import down_counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_e           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else if (load) begin
      count_q  <= load_val;
      reload_q <= load_val;
      tc_q     <= 1'b0;
      state_q  <= (load_val != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (count_q == WIDTH'(1)) begin
        tc_q <= 1'b1;
        if (auto_reload) begin
          // Reload register is never zero while in RUN, so count never reads 0 here.
          count_q <= reload_q;
        end else begin
          count_q <= '0;
          state_q <= DONE;
        end
      end else begin
        tc_q    <= 1'b0;
        count_q <= count_q - WIDTH'(1);
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  // Outputs decode straight from flops, so they are glitch-free and edge-aligned.
  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_reload.sv
module tb_down_counter_reload;

  localparam int W = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         load;
  logic [W-1:0] load_val;
  logic         en;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         busy;
  logic         tc;
  logic         done;

  int checks = 0;
  int errors = 0;

  down_counter_reload #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .count       (count),
    .busy        (busy),
    .tc          (tc),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Inputs are changed 1ns after a rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic l, input int lv, input logic e, input logic ar);
    load        = l;
    load_val    = W'(lv);
    en          = e;
    auto_reload = ar;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 0, 1'b0, 1'b0);
    #2;
    checks++;
    if ({count, busy, tc, done} !== 6'b000_000) begin
      errors++;
      $display("FAIL reset_async: got %b exp %b", {count, busy, tc, done}, 6'b0);
    end
    tick();
    tick();
    rst = 1'b1;
    drive(1'b0, 0, 1'b1, 1'b0);
    tick();
    checks++;
    if ({count, busy, tc, done} !== 6'b000_000) begin
      errors++;
      $display("FAIL reset_en_idle: got %b exp %b", {count, busy, tc, done}, 6'b0);
    end
  endtask

  task automatic test_one_shot();
    logic [5:0] exp;
    drive(1'b1, 5, 1'b1, 1'b0);
    tick();
    checks++;
    if ({count, busy, tc, done} !== {3'd5, 3'b100}) begin
      errors++;
      $display("FAIL oneshot_load: got %b exp %b", {count, busy, tc, done}, {3'd5, 3'b100});
    end
    load = 1'b0;
    for (int k = 4; k >= 0; k--) begin
      tick();
      exp = (k == 0) ? {3'd0, 3'b011} : {3'(k), 3'b100};
      checks++;
      if ({count, busy, tc, done} !== exp) begin
        errors++;
        $display("FAIL oneshot_step%0d: got %b exp %b", k, {count, busy, tc, done}, exp);
      end
    end
    tick();
    checks++;
    if ({count, busy, tc, done} !== {3'd0, 3'b001}) begin
      errors++;
      $display("FAIL oneshot_hold: got %b exp %b", {count, busy, tc, done}, {3'd0, 3'b001});
    end
  endtask

  task automatic test_auto_reload();
    int seq[8] = '{2, 1, 3, 2, 1, 3, 2, 1};
    logic [5:0] exp;
    drive(1'b1, 3, 1'b1, 1'b1);
    tick();
    checks++;
    if ({count, busy, tc, done} !== {3'd3, 3'b100}) begin
      errors++;
      $display("FAIL reload_load: got %b exp %b", {count, busy, tc, done}, {3'd3, 3'b100});
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {3'(seq[i]), 1'b1, (seq[i] == 3), 1'b0};
      checks++;
      if ({count, busy, tc, done} !== exp) begin
        errors++;
        $display("FAIL reload_step%0d: got %b exp %b", i, {count, busy, tc, done}, exp);
      end
    end
  endtask

  task automatic test_en_gating();
    logic pat[6] = '{1, 0, 1, 1, 0, 1};
    int   cnt[6] = '{3, 3, 2, 1, 1, 0};
    logic [5:0] exp;
    drive(1'b1, 4, 1'b1, 1'b0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      en = pat[i];
      tick();
      exp = (i == 5) ? {3'd0, 3'b011} : {3'(cnt[i]), 3'b100};
      checks++;
      if ({count, busy, tc, done} !== exp) begin
        errors++;
        $display("FAIL gating_step%0d: got %b exp %b", i, {count, busy, tc, done}, exp);
      end
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 2, 1'b1, 1'b0);
    tick();
    load = 1'b0;
    tick();
    checks++;
    if (count !== 3'd1) begin
      errors++;
      $display("FAIL prio_pre: got %0d exp 1", count);
    end
    drive(1'b1, 6, 1'b1, 1'b0);
    tick();
    checks++;
    if ({count, busy, tc, done} !== {3'd6, 3'b100}) begin
      errors++;
      $display("FAIL prio_load: got %b exp %b", {count, busy, tc, done}, {3'd6, 3'b100});
    end
  endtask

  task automatic test_load_zero_full();
    logic [5:0] exp;
    drive(1'b1, 0, 1'b1, 1'b0);
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({count, busy, tc, done} !== 6'b0) begin
        errors++;
        $display("FAIL zero_%0d: got %b exp %b", i, {count, busy, tc, done}, 6'b0);
      end
      tick();
    end
    drive(1'b1, 7, 1'b1, 1'b0);
    tick();
    load = 1'b0;
    for (int k = 6; k >= 0; k--) begin
      tick();
      exp = (k == 0) ? {3'd0, 3'b011} : {3'(k), 3'b100};
      checks++;
      if ({count, busy, tc, done} !== exp) begin
        errors++;
        $display("FAIL full_step%0d: got %b exp %b", k, {count, busy, tc, done}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 5, 1'b1, 1'b0);
    tick();
    load = 1'b0;
    tick();
    tick();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL areset_pre: got %0d exp 3", count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({count, busy, tc, done} !== 6'b0) begin
      errors++;
      $display("FAIL areset_mid: got %b exp %b", {count, busy, tc, done}, 6'b0);
    end
    #2;
    rst = 1'b1;
    tick();
    checks++;
    if ({count, busy, tc, done} !== 6'b0) begin
      errors++;
      $display("FAIL areset_en_only: got %b exp %b", {count, busy, tc, done}, 6'b0);
    end
    // Cut a tc pulse short.
    drive(1'b1, 1, 1'b1, 1'b1);
    tick();
    load = 1'b0;
    tick();
    checks++;
    if ({count, tc} !== {3'd1, 1'b1}) begin
      errors++;
      $display("FAIL areset_tc_pre: got %b exp %b", {count, tc}, {3'd1, 1'b1});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({count, busy, tc, done} !== 6'b0) begin
      errors++;
      $display("FAIL areset_tc_cut: got %b exp %b", {count, busy, tc, done}, 6'b0);
    end
    #2;
    rst = 1'b1;
    drive(1'b0, 0, 1'b0, 1'b0);
  endtask

  // Reference model in terms of the described behaviour: phase 0 idle, 1 counting, 2 finished.
  task automatic test_random();
    int m_count = 0, m_reload = 0, m_phase = 0;
    logic m_tc = 1'b0;
    logic [5:0] exp;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 9) == 0), $urandom_range(0, 7),
            ($urandom_range(0, 3) != 0), $urandom_range(0, 1));
      tick();
      if (load) begin
        m_count  = int'(load_val);
        m_reload = int'(load_val);
        m_phase  = (m_count == 0) ? 0 : 1;
        m_tc     = 1'b0;
      end else if (m_phase == 1 && en) begin
        m_tc = (m_count == 1);
        if (m_count > 1) m_count = m_count - 1;
        else if (auto_reload) m_count = m_reload;
        else begin
          m_count = 0;
          m_phase = 2;
        end
      end else begin
        m_tc = 1'b0;
      end
      exp = {3'(m_count), (m_phase == 1), m_tc, (m_phase == 2)};
      checks++;
      if ({count, busy, tc, done} !== exp) begin
        errors++;
        $display("FAIL random_c%0d: got %b exp %b", c, {count, busy, tc, done}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_en_gating();
    test_load_priority();
    test_load_zero_full();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
